// File: rtl/data_bus_xbar.sv
// Command-queued data crossbar: moves one source word per cycle into any subset of
// destination registers, with a registered data word and one-cycle load strobe per destination.
module data_bus_xbar #(
  parameter int WIDTH     = 8,
  parameter int NUM_SRC   = 12,
  parameter int NUM_DST   = 11,
  parameter int SEL_W     = 4,
  parameter int CMD_DEPTH = 4,
  parameter int CNT_W     = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_SRC*WIDTH-1:0]   src_data,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [SEL_W-1:0]           cmd_src,
  input  logic [NUM_DST-1:0]         cmd_dst_mask,
  input  logic                       hold,
  output logic [NUM_DST*WIDTH-1:0]   dst_data,
  output logic [NUM_DST-1:0]         dst_load,
  output logic [CNT_W-1:0]           cmd_count,
  output logic                       busy,
  output logic                       sel_err
);

  localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CMD_DEPTH);

  logic [SEL_W-1:0]   fifo_src  [CMD_DEPTH];
  logic [NUM_DST-1:0] fifo_mask [CMD_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push;
  logic               pop;
  logic [SEL_W-1:0]   head_src;
  logic [NUM_DST-1:0] head_mask;
  logic               src_ok;
  logic [WIDTH-1:0]   src_word;

  assign cmd_ready = (count != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (count != '0) && !hold;
  assign head_src  = fifo_src[rd_ptr];
  assign head_mask = fifo_mask[rd_ptr];
  assign src_ok    = ({1'b0, head_src} < (SEL_W+1)'(NUM_SRC));
  assign cmd_count = count;
  assign busy      = (count != '0);

  // Out-of-range selects match no source and therefore deliver zero.
  always_comb begin
    src_word = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (head_src == SEL_W'(i)) src_word = src_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_src[wr_ptr]  <= cmd_src;
      fifo_mask[wr_ptr] <= cmd_dst_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      dst_data <= '0;
      dst_load <= '0;
      sel_err  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
      dst_load <= pop ? head_mask : '0;
      if (pop) begin
        for (int j = 0; j < NUM_DST; j++) begin
          if (head_mask[j]) dst_data[j*WIDTH +: WIDTH] <= src_word;
        end
        if (!src_ok) sel_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_bus_xbar.sv
// Self-checking bench for data_bus_xbar: scenario tasks with a scoreboard of expected
// destination writes, compared when each command executes.
module tb_data_bus_xbar;
  localparam int WIDTH     = 8;
  localparam int NUM_SRC   = 12;
  localparam int NUM_DST   = 11;
  localparam int SEL_W     = 4;
  localparam int CMD_DEPTH = 4;
  localparam int CNT_W     = 3;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [SEL_W-1:0]         cmd_src;
  logic [NUM_DST-1:0]       cmd_dst_mask;
  logic                     hold;
  logic [NUM_DST*WIDTH-1:0] dst_data;
  logic [NUM_DST-1:0]       dst_load;
  logic [CNT_W-1:0]         cmd_count;
  logic                     busy;
  logic                     sel_err;

  data_bus_xbar #(
    .WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .NUM_DST(NUM_DST),
    .SEL_W(SEL_W), .CMD_DEPTH(CMD_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .src_data(src_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_src(cmd_src),
    .cmd_dst_mask(cmd_dst_mask), .hold(hold), .dst_data(dst_data),
    .dst_load(dst_load), .cmd_count(cmd_count), .busy(busy), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_DST-1:0] mask;
    logic [WIDTH-1:0]   word;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] model_dst [NUM_DST];
  int               errors = 0;
  int               checks = 0;

  function automatic logic [NUM_DST*WIDTH-1:0] model_packed();
    logic [NUM_DST*WIDTH-1:0] p;
    for (int j = 0; j < NUM_DST; j++) p[j*WIDTH +: WIDTH] = model_dst[j];
    return p;
  endfunction

  // Retire the oldest expected command into the destination model; returns its mask.
  function automatic logic [NUM_DST-1:0] sb_next();
    exp_t e;
    if (sb.size() == 0) return '0;
    e = sb.pop_front();
    for (int j = 0; j < NUM_DST; j++) if (e.mask[j]) model_dst[j] = e.word;
    return e.mask;
  endfunction

  function automatic void model_clear();
    for (int j = 0; j < NUM_DST; j++) model_dst[j] = '0;
    sb.delete();
  endfunction

  task automatic set_src(input int i, input logic [WIDTH-1:0] v);
    src_data[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic offer(input logic [SEL_W-1:0] s, input logic [NUM_DST-1:0] m,
                       input logic [WIDTH-1:0] w, input bit store);
    exp_t e;
    cmd_valid    = 1'b1;
    cmd_src      = s;
    cmd_dst_mask = m;
    e.mask = m;
    e.word = w;
    if (store) sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    tick();
    reset_n = 1'b0;
    model_clear();
    checks++; if (cmd_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", cmd_count); end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_flags: busy=%b ready=%b expected busy=0 ready=1", busy, cmd_ready); end
    checks++; if (dst_data !== '0 || dst_load !== '0) begin errors++; $display("FAIL rst_dst: data=%h load=%h expected zeros", dst_data, dst_load); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL rst_sel_err: got %b expected 0", sel_err); end
  endtask

  task automatic test_single();
    logic [NUM_DST-1:0] m;
    set_src(3, 8'hA5);
    offer(4'd3, 11'h004, 8'hA5, 1'b1);
    tick();
    cmd_valid = 1'b0;
    checks++; if (dst_load !== '0 || cmd_count !== 3'd1) begin errors++; $display("FAIL single_accept: load=%h count=%0d expected load=000 count=1", dst_load, cmd_count); end
    tick();
    m = sb_next();
    checks++; if (dst_load !== m) begin errors++; $display("FAIL single_load: got %h expected %h", dst_load, m); end
    checks++; if (dst_data !== model_packed()) begin errors++; $display("FAIL single_data: got %h expected %h", dst_data, model_packed()); end
    tick();
    checks++; if (dst_load !== '0) begin errors++; $display("FAIL single_strobe_end: got %h expected 000", dst_load); end
    checks++; if (dst_data !== model_packed()) begin errors++; $display("FAIL single_hold_data: got %h expected %h", dst_data, model_packed()); end
  endtask

  task automatic test_multicast();
    logic [NUM_DST-1:0] m;
    set_src(7, 8'h11);
    offer(4'd7, 11'h0C1, 8'h22, 1'b1);
    tick();
    cmd_valid = 1'b0;
    set_src(7, 8'h22);
    tick();
    m = sb_next();
    checks++; if (dst_load !== m) begin errors++; $display("FAIL mcast_load: got %h expected %h", dst_load, m); end
    checks++; if (dst_data !== model_packed()) begin errors++; $display("FAIL mcast_data: got %h expected %h", dst_data, model_packed()); end
  endtask

  task automatic test_full_hold();
    logic [NUM_DST-1:0] m;
    hold = 1'b1;
    for (int k = 0; k < 5; k++) set_src(k, 8'h50 + 8'(k));
    for (int k = 0; k < 5; k++) begin
      offer(SEL_W'(k), NUM_DST'(1) << k, 8'h50 + 8'(k), k < 4);
      tick();
      checks++; if (cmd_count !== CNT_W'(k < 4 ? k + 1 : 4)) begin errors++; $display("FAIL full_count%0d: got %0d expected %0d", k, cmd_count, (k < 4 ? k + 1 : 4)); end
      checks++; if (cmd_ready !== (k < 3)) begin errors++; $display("FAIL full_ready%0d: got %b expected %b", k, cmd_ready, (k < 3)); end
    end
    cmd_valid = 1'b0;
    hold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      m = sb_next();
      checks++; if (dst_load !== m) begin errors++; $display("FAIL drain_load%0d: got %h expected %h", k, dst_load, m); end
      checks++; if (dst_data !== model_packed()) begin errors++; $display("FAIL drain_data%0d: got %h expected %h", k, dst_data, model_packed()); end
      checks++; if (cmd_count !== CNT_W'(3 - k) || busy !== (k < 3)) begin errors++; $display("FAIL drain_count%0d: count=%0d busy=%b expected count=%0d busy=%b", k, cmd_count, busy, 3 - k, (k < 3)); end
    end
    tick();
    checks++; if (dst_load !== '0) begin errors++; $display("FAIL full_dropped: got load %h expected 000", dst_load); end
  endtask

  task automatic test_back_to_back();
    logic [NUM_DST-1:0] m;
    int exp_cnt;
    for (int i = 0; i < 8; i++) set_src(i, 8'h30 + 8'(i * 17));
    for (int k = 0; k < 10; k++) begin
      hold = (k < 2);
      if (k < 8) offer(SEL_W'(k), NUM_DST'(1) << k, 8'h30 + 8'(k * 17), 1'b1);
      else cmd_valid = 1'b0;
      tick();
      exp_cnt = (k < 2) ? k + 1 : (k < 8) ? 2 : 9 - k;
      checks++; if (cmd_count !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL b2b_count%0d: got %0d expected %0d", k, cmd_count, exp_cnt); end
      if (k >= 2) begin
        m = sb_next();
        checks++; if (dst_load !== m) begin errors++; $display("FAIL b2b_load%0d: got %h expected %h", k, dst_load, m); end
        checks++; if (dst_data !== model_packed()) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", k, dst_data, model_packed()); end
      end
    end
  endtask

  task automatic test_bad_src();
    logic [NUM_DST-1:0] m;
    set_src(9, 8'h3C);
    offer(4'd9, 11'h020, 8'h3C, 1'b1);
    tick();
    cmd_valid = 1'b0;
    tick();
    m = sb_next();
    checks++; if (dst_data !== model_packed() || sel_err !== 1'b0) begin errors++; $display("FAIL bad_setup: data=%h sel_err=%b expected %h sel_err=0", dst_data, sel_err, model_packed()); end
    offer(4'd14, 11'h020, 8'h00, 1'b1);
    tick();
    cmd_valid = 1'b0;
    tick();
    m = sb_next();
    checks++; if (dst_load !== m) begin errors++; $display("FAIL bad_load: got %h expected %h", dst_load, m); end
    checks++; if (dst_data !== model_packed()) begin errors++; $display("FAIL bad_data: got %h expected %h", dst_data, model_packed()); end
    checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL bad_sel_err: got %b expected 1", sel_err); end
    tick();
    tick();
    checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL bad_sticky: got %b expected 1", sel_err); end
    offer(4'd0, 11'h000, 8'h00, 1'b1);
    tick();
    cmd_valid = 1'b0;
    checks++; if (cmd_count !== 3'd1) begin errors++; $display("FAIL zmask_queued: got %0d expected 1", cmd_count); end
    tick();
    m = sb_next();
    checks++; if (dst_load !== m || cmd_count !== 3'd0) begin errors++; $display("FAIL zmask_pop: load=%h count=%0d expected load=%h count=0", dst_load, cmd_count, m); end
    checks++; if (dst_data !== model_packed()) begin errors++; $display("FAIL zmask_data: got %h expected %h", dst_data, model_packed()); end
  endtask

  task automatic test_reset_mid();
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      offer(SEL_W'(k), NUM_DST'(3) << k, 8'h00, 1'b0);
      tick();
    end
    checks++; if (cmd_count !== 3'd3) begin errors++; $display("FAIL mid_queued: got %0d expected 3", cmd_count); end
    reset_n = 1'b1;
    hold    = 1'b0;
    offer(4'd1, 11'h7FF, 8'h00, 1'b0);
    tick();
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    model_clear();
    checks++; if (cmd_count !== 3'd0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_count: count=%0d busy=%b ready=%b expected 0 0 1", cmd_count, busy, cmd_ready); end
    checks++; if (dst_data !== model_packed() || dst_load !== '0) begin errors++; $display("FAIL mid_dst: data=%h load=%h expected zeros", dst_data, dst_load); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL mid_sel_err: got %b expected 0", sel_err); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (dst_load !== '0 || cmd_count !== 3'd0) begin errors++; $display("FAIL mid_quiet%0d: load=%h count=%0d expected 000 0", k, dst_load, cmd_count); end
    end
  endtask

  initial begin
    reset_n      = 1'b1;
    hold         = 1'b0;
    cmd_valid    = 1'b0;
    cmd_src      = '0;
    cmd_dst_mask = '0;
    src_data     = '0;
    model_clear();
    test_reset();
    test_single();
    test_multicast();
    test_full_hold();
    test_back_to_back();
    test_bad_src();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_bus_xbar.md
Name: data_bus_xbar

Overview:
- Parametrised, command-driven successor to the CPU data bus.
- Moves one WIDTH-bit source word per cycle into any subset of NUM_DST destination registers.
- Transfer commands from decode/control are queued in an internal CMD_DEPTH FIFO and executed in order, one per cycle. Execution pauses while hold is asserted.
- Each destination gets a registered data word and a one-cycle load strobe. Register, ALU, memory and fetch/decode blocks consume these instead of free-running per-destination muxes.

Parameters:
- WIDTH, 8, data word width in bits.
- NUM_SRC, 12, number of source words on src_data.
- NUM_DST, 11, number of destination registers.
- SEL_W, 4, width of cmd_src; must satisfy 2^SEL_W >= NUM_SRC.
- CMD_DEPTH, 4, command FIFO depth (power of two, >= 2).
- CNT_W, 3, width of cmd_count; equals clog2(CMD_DEPTH+1).

Ports:
- clk, input, 1, system clock; all logic updates on rising edge.
- reset_n, input, 1, synchronous reset, active-high despite the name; sampled on rising clk.
- src_data, input, NUM_SRC*WIDTH, packed sources; source i occupies bits [i*WIDTH +: WIDTH].
- cmd_valid, input, 1, command offered.
- cmd_ready, output, 1, FIFO can accept a command.
- cmd_src, input, SEL_W, source index of offered command.
- cmd_dst_mask, input, NUM_DST, destination one-hot/multi-hot mask of offered command.
- hold, input, 1, 1 = do not execute a command this cycle.
- dst_data, output, NUM_DST*WIDTH, packed destination registers; destination j occupies bits [j*WIDTH +: WIDTH].
- dst_load, output, NUM_DST, per-destination load strobe, asserted the cycle dst_data j holds newly written data.
- cmd_count, output, CNT_W, number of queued commands.
- busy, output, 1, cmd_count != 0.
- sel_err, output, 1, sticky flag: an executed command had cmd_src >= NUM_SRC.

Behaviour:

Reset (reset_n=1 at a rising edge):
- FIFO emptied; cmd_count=0, busy=0, cmd_ready=1.
- dst_data all 0, dst_load all 0, sel_err=0.
- Reset wins over simultaneous push/pop. Queued commands are discarded, not executed.

Accept:
- cmd_ready = (cmd_count != CMD_DEPTH), combinational from state only; no dependence on cmd_valid or hold.
- A push occurs when cmd_valid && cmd_ready at a rising edge. {cmd_src, cmd_dst_mask} is stored at the write pointer.
- When full, cmd_ready=0 and an offered command is not stored. There is no pass-through, even if a pop happens the same cycle.

Execute:
- A pop occurs at a rising edge when cmd_count != 0 && !hold. It consumes the oldest entry only; a command pushed in the same edge is never executed in that edge.
- src_data is sampled at the pop edge, not at the accept edge.
- For each j with mask[j]=1: dst_data j <= src word cmd_src. If cmd_src >= NUM_SRC, dst_data j <= 0 and sel_err <= 1.
- sel_err is also set for an out-of-range cmd_src with mask=0.
- dst_load <= mask, for one cycle. Destinations with mask[j]=0 keep their value.
- Mask all-zero: command is consumed, no destination changes, dst_load=0.
- Cycles with no pop: dst_load <= 0 and dst_data holds.

Latency and throughput:
- A command accepted at edge t, with an empty FIFO and hold=0, executes at edge t+1.
- The new dst_data and dst_load=1 are visible after edge t+1.
- Sustained throughput is 1 command/cycle with cmd_valid held high.

Counter and pointers:
- Simultaneous push+pop leaves cmd_count unchanged.
- Pointers wrap modulo CMD_DEPTH.
- cmd_count never exceeds CMD_DEPTH and never underflows.

hold:
- Freezes execution only; pushes continue until full.
- Deasserting hold resumes with the oldest entry on the next edge.

sel_err clears only on reset.

Test Plan:
1. Reset then single transfer: src3=8'hA5, push {src=3, mask=11'h004}. Result: next cycle dst2=A5, dst_load=004, one cycle later dst_load=000, dst2 still A5, others 00.
2. Multicast and live sampling: push {src=7, mask=11'h0C1} with src7=8'h11. Change src7 to 8'h22 in the accept cycle only. Result: dst0/6/7 = 8'h22 (sampled at pop edge).
3. Full/hold: hold=1, push 5 commands back-to-back. Result: cmd_count 1,2,3,4; cmd_ready=0 after 4th, 5th not stored. Release hold: 4 pops in order on consecutive edges, cmd_count 3,2,1,0, busy drops with cmd_count=0.
4. Simultaneous push+pop at count=2 (hold=0): cmd_count stays 2. Commands complete in FIFO order across pointer wrap (8 commands total, distinct dst values verified).
5. Out-of-range source: dst5=8'h3C, push {src=14, mask=11'h020}. Result: dst5=00, dst_load=020, sel_err=1 and stays 1. Then push {src=0, mask=0}: no dst change, dst_load=000.
6. Reset mid-operation: 3 queued commands with hold=1, assert reset_n=1 for one edge. Result: cmd_count=0, all dst_data=00, sel_err=0, no dst_load pulses after hold release.
